pointwise_stream_unit: RTL

- Parametrised successor to the single-lane fixed-function pointwise accelerator.
- Streams an image of IMG_W x IMG_H pixels through LANES parallel lanes and applies a runtime-selectable per-pixel op.
- Adds downstream backpressure (out_ready), a credit-limited output FIFO, frame counting and a done pulse.
- Sits between the input global-wrapper stream and the output stencil writer.

---
 rtl/pointwise_pkg.sv | 48 ++++
 rtl/pw_stream_fifo.sv | 67 ++++++
 rtl/pointwise_stream_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pointwise_pkg.sv
// pointwise_pkg: op/state enums and the per-lane pointwise op.
// Build macro POINTWISE_SAT_EN turns wrap into saturation for mul/add/shl.
package pointwise_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_ADD  = 2'd1,
        OP_SHL  = 2'd2,
        OP_PASS = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Widest pixel the op function handles.
    localparam int unsigned OP_MAX_W = 32;

    // One lane: x and c are zero-extended pixels of width w (w <= 32).
    function automatic logic [31:0] pw_op(
        input op_e         m,
        input logic [31:0] x,
        input logic [31:0] c,
        input int unsigned w
    );
        logic [63:0] full;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        full = '0;
        unique case (m)
            OP_MUL:  full = {32'd0, x} * {32'd0, c};
            OP_ADD:  full = {32'd0, x} + {32'd0, c};
            OP_SHL:  full = {32'd0, x} << c[3:0];
            OP_PASS: full = {32'd0, x};
        endcase
`ifdef POINTWISE_SAT_EN
        if (m != OP_PASS && (full & ~mask) != 64'd0) begin
            full = mask;
        end
`endif
        full = full & mask;
        return full[31:0];
    endfunction

endpackage

// File: rtl/pw_stream_fifo.sv
// pw_stream_fifo: synchronous FIFO, first word registered, with count.
// Pop on an empty FIFO is ignored; the data port reads zero when empty.
module pw_stream_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          full;
    logic          wr_ok;
    logic          rd_ok;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign valid    = (cnt != '0);
    assign rd_ok    = pop && valid;
    assign wr_ok    = push && (!full || rd_ok);
    assign pop_data = valid ? mem[rd_ptr] : '0;
    assign count    = cnt;

    // Storage array; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; clear empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pointwise_stream_unit.sv
// pointwise_stream_unit: LANES-wide per-pixel op stream with credit flow.
// Define POINTWISE_SAT_EN for saturating mul/add/shl (see pointwise_pkg).
module pointwise_stream_unit
    import pointwise_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int LANES       = 1,
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 64,
    parameter int PIPE_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [1:0]              cfg_mode,
    input  logic [DATA_W-1:0]       cfg_const,
    output logic                    in_read_en,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    done,
    output logic                    busy
);

    localparam int VW   = LANES * DATA_W;
    localparam int NVEC = IMG_W * IMG_H / LANES;
    localparam int CNTW = $clog2(NVEC + 1);
    localparam int FW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CW   = $clog2(FIFO_DEPTH + PIPE_STAGES + 2) + 1;

    localparam logic [CNTW-1:0] NV      = CNTW'(NVEC);
    localparam logic [CNTW-1:0] NV_LAST = CNTW'(NVEC - 1);

    state_e              state;
    state_e              state_nx;
    op_e                 mode_q;
    logic [DATA_W-1:0]   const_q;
    logic [CNTW-1:0]     rd_cnt;
    logic [CNTW-1:0]     acc_cnt;
    logic                rd_pend;
    logic [VW-1:0]       pipe_d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] pipe_v;
    logic [VW-1:0]       op_res;
    logic [FW-1:0]       fifo_cnt;
    logic [CW-1:0]       inflight;
    logic                credit_ok;
    logic                pop;

    assign pop = out_valid && out_ready;

    // Apply the latched op to every lane of the incoming vector.
    always_comb begin
        op_res = '0;
        for (int l = 0; l < LANES; l++) begin
            op_res[l*DATA_W +: DATA_W] = DATA_W'(pw_op(
                mode_q,
                32'(in_data[l*DATA_W +: DATA_W]),
                32'(const_q),
                DATA_W));
        end
    end

    // Vectors already promised a FIFO slot: pending read plus pipeline.
    always_comb begin
        inflight = CW'(rd_pend);
        for (int i = 0; i < PIPE_STAGES; i++) begin
            inflight = inflight + CW'(pipe_v[i]);
        end
        credit_ok = (CW'(fifo_cnt) + inflight) < CW'(FIFO_DEPTH);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; flush restarts a frame from any state.
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_RUN;
        end else begin
            unique case (state)
                S_IDLE:  state_nx = S_IDLE;
                S_RUN:   if (rd_cnt == NV) state_nx = S_DRAIN;
                S_DRAIN: if (pop && acc_cnt == NV_LAST) state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs; no read is issued in a flush cycle.
    always_comb begin
        in_read_en = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        unique case (state)
            S_RUN: begin
                busy       = 1'b1;
                in_read_en = !flush && (rd_cnt < NV) && credit_ok;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Frame config and read/accept counters, reloaded on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= OP_MUL;
            const_q <= '0;
            rd_cnt  <= '0;
            acc_cnt <= '0;
        end else if (flush) begin
            mode_q  <= op_e'(cfg_mode);
            const_q <= cfg_const;
            rd_cnt  <= '0;
            acc_cnt <= '0;
        end else begin
            if (in_read_en) begin
                rd_cnt <= rd_cnt + CNTW'(1);
            end
            if (pop) begin
                acc_cnt <= acc_cnt + CNTW'(1);
            end
        end
    end

    // Pipeline valids: read pending, then PIPE_STAGES compute stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            pipe_v  <= '0;
        end else if (flush) begin
            rd_pend <= 1'b0;
            pipe_v  <= '0;
        end else begin
            rd_pend   <= in_read_en;
            pipe_v[0] <= rd_pend;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
        end
    end

    // Pipeline data; stage 0 captures the op result of in_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_d[0] <= op_res;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    pw_stream_fifo #(
        .W     (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (pipe_v[PIPE_STAGES-1]),
        .push_data (pipe_d[PIPE_STAGES-1]),
        .pop       (pop),
        .valid     (out_valid),
        .pop_data  (out_data),
        .count     (fifo_cnt)
    );

endmodule
